mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder.sv | 155 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: single-port word-addressed memory slave for a CPU bus.
// It uses a waitrequest handshake and optional wait-state stalling.
// Optional feature macro: RESP_STALL_EN. When it is defined, each access
// takes WAIT_CYCLES cycles. When it is undefined, every access completes in
// the cycle after the request and the WAIT state is never entered.
module mem_bus_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef RESP_STALL_EN
    localparam logic [3:0] LAT = 4'(WAIT_CYCLES);
`else
    localparam logic [3:0] LAT = 4'd1;
    localparam int unsigned unusedWaitCycles = WAIT_CYCLES;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        isWrite_q, isWrite_d;
    logic [31:0] readdata_q, readdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      srcAddr;
    logic [31:0]      srcOff;
    logic [IDX_W-1:0] wordIdx;
    logic             srcInRange;
    logic             memWe;
    logic             entryIsWrite;
    logic             unusedAddrBits;

    // Word selection: the incoming address while IDLE (single-cycle reads need
    // it before it is latched), the latched address in every other state.
    always_comb begin
        srcAddr    = (state_q == IDLE) ? address : addr_q;
        srcOff     = srcAddr - BASE_ADDR;
        wordIdx    = srcOff[IDX_W+1:2];
        srcInRange = (srcAddr >= BASE_ADDR) && ((srcOff >> 2) < DEPTH_WORDS);
    end

    assign unusedAddrBits = ^srcOff[1:0];

    // Next-state, latching, wait-state counting and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        isWrite_d    = isWrite_q;
        readdata_d   = readdata_q;
        err_d        = 1'b0;
        waitrequest  = 1'b0;
        memWe        = 1'b0;
        entryIsWrite = isWrite_q;

        case (state_q)
            IDLE: begin
                if (read ^ write) begin
                    waitrequest  = 1'b1;
                    addr_d       = address;
                    be_d         = byteenable;
                    wdata_d      = writedata;
                    isWrite_d    = write;
                    entryIsWrite = write;
                    cnt_d        = 4'(LAT - 4'd1);
                    state_d      = (LAT == 4'd1) ? DONE : WAIT;
                end else if (read && write) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                waitrequest = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                memWe   = isWrite_q && srcInRange;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == DONE) && (state_q != DONE) && !entryIsWrite) begin
            readdata_d = srcInRange ? mem[wordIdx] : 32'h0;
        end
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            isWrite_q  <= 1'b0;
            readdata_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            isWrite_q  <= isWrite_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    // Byte-masked write commit at the end of DONE; storage survives reset.
    always_ff @(posedge clk) begin
        if (!reset && memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[wordIdx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign readdata = readdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: self-checking bench for mem_bus_responder.
// Expected read data is queued when a read is issued and is checked on completion.
module tb_mem_bus_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hBFC00000;
`ifdef RESP_STALL_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] expQ [$];

    mem_bus_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic bit modelInRange(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off >> 2) < DEPTH);
    endfunction

    function automatic int modelIdx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off);
    endfunction

    task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input bit scramble, input string tag);
        int          cyc;
        logic [31:0] expData;
        @(posedge clk); #1;
        address    = addr;
        byteenable = be;
        writedata  = wd;
        read       = !wr;
        write      = wr;
        if (wr) begin
            if (modelInRange(addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[modelIdx(addr)][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end else begin
            expQ.push_back(modelInRange(addr) ? model[modelIdx(addr)] : 32'h0);
        end
        @(negedge clk);
        checks++;
        if (waitrequest !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s wait_at_T got %b want 1", tag, waitrequest);
        end
        if (scramble) begin
            @(posedge clk); #1;
            address    = address ^ 32'h4;
            writedata  = ~writedata;
            byteenable = ~byteenable;
        end
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (waitrequest === 1'b0) break;
        end
        checks++;
        if (cyc != LAT) begin
            errors++;
            $display("[TB] FAIL %s latency got %0d want %0d", tag, cyc, LAT);
        end
        if (!wr) begin
            expData = expQ.pop_front();
            checks++;
            if (readdata !== expData) begin
                errors++;
                $display("[TB] FAIL %s readdata got %h want %h", tag, readdata, expData);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s err got %b want 0", tag, err);
        end
        @(posedge clk); #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL reset_wait got %b want 0", waitrequest); end
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", readdata); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, BASE + 32'(4*i), 4'hF, (32'h01010101 * 32'(i)) ^ 32'hA5A5A5A5, 1'b0, "fill");
        end
    endtask

    task automatic test_write_read();
        logic [31:0] held;
        access(1'b1, BASE + 32'd8, 4'hF, 32'hDEADBEEF, 1'b0, "wr_deadbeef");
        access(1'b0, BASE + 32'd8, 4'h0, 32'h0, 1'b0, "rd_deadbeef");
        held = readdata;
        @(negedge clk);
        checks++;
        if (readdata !== 32'hDEADBEEF || held !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL rdata_hold got %h want DEADBEEF", readdata);
        end
        access(1'b1, BASE + 32'd20, 4'hF, 32'hCAFEF00D, 1'b1, "wr_scrambled");
        access(1'b0, BASE + 32'd20, 4'h0, 32'h0, 1'b1, "rd_scrambled");
        access(1'b0, BASE + 32'd16, 4'h0, 32'h0, 1'b0, "rd_neighbour");
    endtask

    task automatic test_byte_enable();
        access(1'b1, BASE + 32'd12, 4'hF, 32'h11223344, 1'b0, "be_init");
        access(1'b1, BASE + 32'd12, 4'b0101, 32'hAABBCCDD, 1'b0, "be_partial");
        access(1'b0, BASE + 32'd12, 4'h0, 32'h0, 1'b0, "be_read");
        access(1'b0, BASE + 32'd13, 4'h0, 32'h0, 1'b0, "be_read_lowbits");
    endtask

    task automatic test_out_of_range();
        access(1'b0, BASE - 32'd4, 4'h0, 32'h0, 1'b0, "oor_below");
        access(1'b0, BASE + 32'(4*DEPTH), 4'h0, 32'h0, 1'b0, "oor_above");
        access(1'b1, BASE + 32'(4*DEPTH), 4'hF, 32'h12345678, 1'b0, "oor_write");
        access(1'b1, BASE - 32'd4, 4'hF, 32'h87654321, 1'b0, "oor_write_below");
        access(1'b0, BASE, 4'h0, 32'h0, 1'b0, "oor_word0");
        access(1'b0, BASE + 32'(4*(DEPTH-1)), 4'h0, 32'h0, 1'b0, "oor_lastword");
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        address    = BASE + 32'd8;
        writedata  = 32'h00000000;
        byteenable = 4'hF;
        read       = 1'b1;
        write      = 1'b1;
        @(negedge clk);
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL illegal_wait got %b want 0", waitrequest); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err_T got %b want 0", err); end
        @(posedge clk); #1;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_T1 got %b want 1", err); end
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL illegal_wait_T1 got %b want 0", waitrequest); end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err_T2 got %b want 0", err); end
        access(1'b0, BASE + 32'd8, 4'h0, 32'h0, 1'b0, "illegal_nochange");
    endtask

    task automatic test_reset_abort();
        access(1'b0, BASE + 32'd12, 4'h0, 32'h0, 1'b0, "abort_preread");
        @(posedge clk); #1;
        address    = BASE;
        writedata  = 32'h0BADF00D;
        byteenable = 4'hF;
        write      = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("[TB] FAIL abort_rdata got %h want 0", readdata); end
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL abort_wait got %b want 0", waitrequest); end
        access(1'b0, BASE, 4'h0, 32'h0, 1'b0, "abort_oldvalue");
    endtask

    task automatic test_back_to_back();
        logic        expWait;
        logic [31:0] expData;
        @(posedge clk); #1;
        address = BASE + 32'd4;
        read    = 1'b1;
        write   = 1'b0;
        for (int k = 0; k < 3*(LAT+1); k++) begin
            if ((k % (LAT+1)) == 0) expQ.push_back(model[1]);
            @(negedge clk);
            expWait = ((k % (LAT+1)) != LAT);
            checks++;
            if (waitrequest !== expWait) begin
                errors++;
                $display("[TB] FAIL b2b_wait cycle %0d got %b want %b", k, waitrequest, expWait);
            end
            if (!expWait) begin
                expData = expQ.pop_front();
                checks++;
                if (readdata !== expData) begin
                    errors++;
                    $display("[TB] FAIL b2b_rdata cycle %0d got %h want %h", k, readdata, expData);
                end
            end
        end
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            a = BASE + 32'(4 * $urandom_range(0, DEPTH-1));
            access(1'b1, a, 4'($urandom_range(0, 15)), $urandom, 1'b0, "rand_wr");
            access(1'b0, a, 4'h0, 32'h0, 1'b0, "rand_rd");
        end
    endtask

    initial begin
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = 32'h0;
        byteenable = 4'h0;
        writedata  = 32'h0;
        test_reset();
        test_fill();
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
